// File: rtl/gpio_packet_shifter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : gpio_packet_shifter
// Brief    : GPIO serial front end: assembles command packets from gpio_sdi and
//            serialises SRAM read data onto gpio_sdo. Optional trailing even
//            parity bit on RX frames when PARITY_CHECK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module gpio_packet_shifter #(
  parameter int PKT_W = 86,
  parameter int RD_W  = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             gpio_start,
  input  logic             gpio_bit_vld,
  input  logic             gpio_sdi,
  output logic [PKT_W-1:0] packet,
  output logic             packet_vld,
  output logic             rx_busy,
  input  logic             rd_load,
  input  logic [RD_W-1:0]  rd_data,
  output logic             gpio_sdo,
  output logic             tx_busy,
  output logic             parity_err
);

`ifdef PARITY_CHECK_EN
  localparam int c_frame_w = PKT_W + 1;
`else
  localparam int c_frame_w = PKT_W;
`endif
  localparam int c_cnt_w  = $clog2(c_frame_w + 1);
  localparam int c_tcnt_w = $clog2(RD_W);

  localparam logic [c_cnt_w-1:0]  c_last_idx = c_cnt_w'(c_frame_w - 1);
  localparam logic [c_tcnt_w-1:0] c_tx_top   = c_tcnt_w'(RD_W - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_SHIFT = 2'd1,
    RX_DONE  = 2'd2
  } rx_state_t;

  typedef enum logic {
    TX_IDLE  = 1'b0,
    TX_SHIFT = 1'b1
  } tx_state_t;

  // --------------------------------------------------------------------------
  // RX engine
  // --------------------------------------------------------------------------
  rx_state_t              r_rx_state;
  rx_state_t              w_rx_next;
  logic [c_cnt_w-1:0]     r_rx_cnt;
  logic [c_frame_w-1:0]   r_sreg;
  logic [PKT_W-1:0]       r_packet;
  logic                   r_packet_vld;
  logic [PKT_W-1:0]       w_frame_pkt;
  logic                   w_frame_ok;
  logic                   w_bit_take;

  // A start strobe always wins over a coincident bit strobe.
  assign w_bit_take = gpio_bit_vld && !gpio_start;

`ifdef PARITY_CHECK_EN
  assign w_frame_pkt = r_sreg[c_frame_w-1:1];
  assign w_frame_ok  = ~^r_sreg;
`else
  assign w_frame_pkt = r_sreg;
  assign w_frame_ok  = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RX_IDLE;
    end else begin
      r_rx_state <= w_rx_next;
    end
  end

  always_comb begin
    w_rx_next = r_rx_state;
    case (r_rx_state)
      RX_IDLE: begin
        if (gpio_start) begin
          w_rx_next = RX_SHIFT;
        end
      end
      RX_SHIFT: begin
        if (w_bit_take && (r_rx_cnt == c_last_idx)) begin
          w_rx_next = RX_DONE;
        end
      end
      RX_DONE: begin
        w_rx_next = RX_IDLE;
      end
      default: begin
        w_rx_next = RX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_cnt     <= '0;
      r_sreg       <= '0;
      r_packet     <= '0;
      r_packet_vld <= 1'b0;
    end else begin
      r_packet_vld <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          if (gpio_start) begin
            r_rx_cnt <= '0;
            r_sreg   <= '0;
          end
        end
        RX_SHIFT: begin
          if (gpio_start) begin
            r_rx_cnt <= '0;
            r_sreg   <= '0;
          end else if (gpio_bit_vld) begin
            r_sreg   <= {r_sreg[c_frame_w-2:0], gpio_sdi};
            r_rx_cnt <= r_rx_cnt + c_cnt_w'(1);
          end
        end
        RX_DONE: begin
          // The packet register only ever changes here, so it is never torn.
          if (w_frame_ok) begin
            r_packet     <= w_frame_pkt;
            r_packet_vld <= 1'b1;
          end
        end
        default: begin
          r_rx_cnt <= '0;
        end
      endcase
    end
  end

  assign packet     = r_packet;
  assign packet_vld = r_packet_vld;
  assign rx_busy    = (r_rx_state == RX_SHIFT);

`ifdef PARITY_CHECK_EN
  logic r_parity_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_parity_err <= 1'b0;
    end else begin
      r_parity_err <= (r_rx_state == RX_DONE) && !w_frame_ok;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // TX engine
  // --------------------------------------------------------------------------
  tx_state_t             r_tx_state;
  tx_state_t             w_tx_next;
  logic [RD_W-1:0]       r_tsreg;
  logic [c_tcnt_w-1:0]   r_tcount;
  logic                  r_sdo;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tx_state <= TX_IDLE;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_IDLE: begin
        if (rd_load) begin
          w_tx_next = TX_SHIFT;
        end
      end
      TX_SHIFT: begin
        if (r_tcount == '0) begin
          w_tx_next = TX_IDLE;
        end
      end
      default: begin
        w_tx_next = TX_IDLE;
      end
    endcase
  end

  // The MSB is driven straight from rd_data on load so that gpio_sdo and
  // tx_busy line up over exactly RD_W cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_tsreg  <= '0;
      r_tcount <= '0;
      r_sdo    <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: begin
          if (rd_load) begin
            r_tsreg  <= rd_data;
            r_tcount <= c_tx_top;
            r_sdo    <= rd_data[RD_W-1];
          end
        end
        TX_SHIFT: begin
          if (r_tcount == '0) begin
            r_sdo <= 1'b0;
          end else begin
            r_tsreg  <= r_tsreg << 1;
            r_sdo    <= r_tsreg[RD_W-2];
            r_tcount <= r_tcount - c_tcnt_w'(1);
          end
        end
        default: begin
          r_sdo <= 1'b0;
        end
      endcase
    end
  end

  assign gpio_sdo = r_sdo;
  assign tx_busy  = (r_tx_state == TX_SHIFT);

endmodule
`default_nettype wire
